// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode-request / result handshake bundle for alu_ctrl_seq.
//   master : request side (drives flush, in_valid, funct, alu_op, out_ready)
//   slave  : the control sequencer (drives in_ready, out_valid, alu_sel,
//            md_start, md_op, busy, illegal)
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int SEL_W   = 4
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] funct;
  logic [1:0]         alu_op;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   alu_sel;
  logic               md_start;
  logic               md_op;
  logic               busy;
  logic               illegal;

  modport master (
    output flush, in_valid, funct, alu_op, out_ready,
    input  in_ready, out_valid, alu_sel, md_start, md_op, busy, illegal
  );

  modport slave (
    input  flush, in_valid, funct, alu_op, out_ready,
    output in_ready, out_valid, alu_sel, md_start, md_op, busy, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder with a valid/ready result stage and an
// optional multi-cycle multiply/divide occupancy sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : alu_ctrl_seq_if.slave (request in, registered decode out)
// Macro ALU_CTRL_MD_EN: when defined, funct 011000/011010 launch a
// multiply/divide (md_start pulse, MD_CYCLES busy cycles); when undefined
// they decode as illegal and md_start/md_op/busy are tied low.
module alu_ctrl_seq #(
  parameter int FUNCT_W   = 6,
  parameter int SEL_W     = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctrl_seq_if.slave bus
);

  if (MD_CYCLES < 1 || SEL_W < 4) begin : g_bad_cfg
    $error("alu_ctrl_seq: MD_CYCLES must be >= 1 and SEL_W >= 4");
  end

`ifdef ALU_CTRL_MD_EN
  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, OUT, MD_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, OUT} state_t;
`endif

  state_t           state, state_nxt;
  logic             rdy, accept;
  logic [SEL_W-1:0] dec_sel, sel_q;
  logic             dec_ill, ill_q;
`ifdef ALU_CTRL_MD_EN
  logic             dec_md, dec_mdop;
  logic [CW-1:0]    cnt;
  logic             start_q, mdop_q;
`endif

  // flush wins over everything, so a flushed cycle never accepts
  assign rdy          = !bus.flush && (state == IDLE || (state == OUT && bus.out_ready));
  assign accept       = bus.in_valid && rdy;
  assign bus.in_ready = rdy;

  always_comb begin
    dec_sel = '0;
    dec_ill = 1'b0;
`ifdef ALU_CTRL_MD_EN
    dec_md   = 1'b0;
    dec_mdop = 1'b0;
`endif
    case (bus.alu_op)
      2'b00: dec_sel = SEL_W'(4'b0010);
      2'b01: dec_sel = SEL_W'(4'b0110);
      2'b10: begin
        case (bus.funct)
          FUNCT_W'(6'b100000): dec_sel = SEL_W'(4'b0010);
          FUNCT_W'(6'b100010): dec_sel = SEL_W'(4'b0110);
          FUNCT_W'(6'b100100): dec_sel = SEL_W'(4'b0000);
          FUNCT_W'(6'b100101): dec_sel = SEL_W'(4'b0001);
          FUNCT_W'(6'b100111): dec_sel = SEL_W'(4'b1100);
          FUNCT_W'(6'b101010): dec_sel = SEL_W'(4'b0111);
`ifdef ALU_CTRL_MD_EN
          FUNCT_W'(6'b011000): begin dec_sel = SEL_W'(4'b1000); dec_md = 1'b1; end
          FUNCT_W'(6'b011010): begin dec_sel = SEL_W'(4'b1001); dec_md = 1'b1; dec_mdop = 1'b1; end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_sel = '1;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE, OUT: begin
          if (accept) begin
`ifdef ALU_CTRL_MD_EN
            state_nxt = dec_md ? MD_WAIT : OUT;
`else
            state_nxt = OUT;
`endif
          end else if (state == IDLE || bus.out_ready) begin
            state_nxt = IDLE;
          end
        end
`ifdef ALU_CTRL_MD_EN
        MD_WAIT: if (cnt == '0) state_nxt = OUT;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel_q <= dec_sel;
        ill_q <= dec_ill;
      end
    end
  end

  assign bus.out_valid = (state == OUT);
  assign bus.alu_sel   = sel_q;
  assign bus.illegal   = ill_q;

`ifdef ALU_CTRL_MD_EN
  // cnt walks MD_CYCLES-1 .. 0 across the MD_WAIT cycles and parks at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      start_q <= 1'b0;
      mdop_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (bus.flush) cnt <= '0;
      else if (accept && dec_md) begin
        cnt     <= CW'(MD_CYCLES - 1);
        start_q <= 1'b1;
      end else if (state == MD_WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (accept) mdop_q <= dec_mdop;
    end
  end

  assign bus.md_start = start_q;
  assign bus.md_op    = mdop_q;
  assign bus.busy     = (state == MD_WAIT);
`else
  assign bus.md_start = 1'b0;
  assign bus.md_op    = 1'b0;
  assign bus.busy     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for alu_ctrl_seq. The driver keeps a
// timing model (when is a result due, is the unit free) and pushes the
// expected decode per accepted request; the monitor compares whatever the
// DUT presents with out_valid against the queue head.
module tb_alu_ctrl_seq;
  localparam int MDC = 4;
`ifdef ALU_CTRL_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] sel;
    logic       ill;
    logic       mdop;
  } exp_t;

  logic clk, reset;
  alu_ctrl_seq_if #(.FUNCT_W(6), .SEL_W(4)) bus ();

  alu_ctrl_seq #(.FUNCT_W(6), .SEL_W(4), .MD_CYCLES(MDC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_pass = 0, n_tot = 0;
  int   cyc = 0, rdy_cyc = 0, md_cyc = -1;
  bit   pending = 0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endfunction

  // Reference decode straight from the opcode table
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                output exp_t e, output bit md);
    e.sel = 4'hF; e.ill = 1'b1; e.mdop = 1'b0; md = 1'b0;
    if (op == 2'b00) begin e.sel = 4'h2; e.ill = 1'b0; end
    else if (op == 2'b01) begin e.sel = 4'h6; e.ill = 1'b0; end
    else if (op == 2'b10) begin
      case (fn)
        6'h20: begin e.sel = 4'h2; e.ill = 1'b0; end
        6'h22: begin e.sel = 4'h6; e.ill = 1'b0; end
        6'h24: begin e.sel = 4'h0; e.ill = 1'b0; end
        6'h25: begin e.sel = 4'h1; e.ill = 1'b0; end
        6'h27: begin e.sel = 4'hC; e.ill = 1'b0; end
        6'h2A: begin e.sel = 4'h7; e.ill = 1'b0; end
        6'h18: if (MD_EN) begin e.sel = 4'h8; e.ill = 1'b0; md = 1'b1; end
        6'h1A: if (MD_EN) begin e.sel = 4'h9; e.ill = 1'b0; e.mdop = 1'b1; md = 1'b1; end
        default: ;
      endcase
    end
  endfunction

  // One clock of stimulus plus the per-cycle control checks
  task automatic step(input logic iv, input logic [1:0] op, input logic [5:0] fn,
                      input logic ordy, input logic fl);
    exp_t e;
    bit   md, due, exp_ir;
    @(negedge clk);
    bus.in_valid = iv; bus.alu_op = op; bus.funct = fn;
    bus.out_ready = ordy; bus.flush = fl;
    #2;
    due    = pending && (cyc >= rdy_cyc);
    exp_ir = !fl && (!pending || (due && ordy));
    chk("in_ready",  8'(bus.in_ready),  8'(exp_ir));
    chk("out_valid", 8'(bus.out_valid), 8'(due));
    chk("busy",      8'(bus.busy),      8'(pending && !due));
    chk("md_start",  8'(bus.md_start),  8'(cyc == md_cyc));
    if (fl) begin
      q.delete(); pending = 0; md_cyc = -1;
    end else if (iv && exp_ir) begin
      model(op, fn, e, md);
      q.push_back(e);
      pending = 1;
      rdy_cyc = md ? cyc + MDC + 1 : cyc + 1;
      md_cyc  = md ? cyc + 1 : -1;
    end else if (due && ordy) begin
      pending = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.in_valid = 1'b0; bus.flush = 1'b0;
    #1;
    chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_alu_sel",   8'(bus.alu_sel),   8'd0);
    chk("rst_illegal",   8'(bus.illegal),   8'd0);
    chk("rst_md_op",     8'(bus.md_op),     8'd0);
    chk("rst_md_start",  8'(bus.md_start),  8'd0);
    chk("rst_busy",      8'(bus.busy),      8'd0);
    q.delete(); pending = 0; md_cyc = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare the presented result against the queue head
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 8'd1, 8'd0);
        else begin
          chk("alu_sel", 8'(bus.alu_sel), 8'(q[0].sel));
          chk("illegal", 8'(bus.illegal), 8'(q[0].ill));
          chk("md_op",   8'(bus.md_op),   8'(q[0].mdop));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  logic [5:0] fn_tab [8];

  initial begin
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
    fn_tab[4] = 6'h27; fn_tab[5] = 6'h2A; fn_tab[6] = 6'h18; fn_tab[7] = 6'h1A;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    #1;
    chk("init_out_valid", 8'(bus.out_valid), 8'd0);
    chk("init_alu_sel",   8'(bus.alu_sel),   8'd0);
    chk("init_busy",      8'(bus.busy),      8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // sub via funct
    step(1, 2'b10, 6'h22, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    // add, and, slt back to back
    step(1, 2'b10, 6'h20, 1, 0);
    step(1, 2'b10, 6'h24, 1, 0);
    step(1, 2'b10, 6'h2A, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    // stall in OUT with a request waiting
    step(1, 2'b00, 6'h00, 0, 0);
    repeat (3) step(1, 2'b01, 6'h00, 0, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    // illegal forms
    step(1, 2'b11, 6'h20, 1, 0);
    step(1, 2'b10, 6'h01, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    // multiply/divide funct codes (illegal when the feature is off)
    step(1, 2'b10, 6'h1A, 1, 0);
    repeat (6) step(1, 2'b00, 6'h00, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    // flush two cycles into a multiply, with a request pending
    step(1, 2'b10, 6'h18, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    step(1, 2'b00, 6'h00, 1, 1);
    repeat (6) step(0, 2'b00, 6'h00, 1, 0);
    // reset while an operation is outstanding
    step(1, 2'b10, 6'h18, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    do_reset();
    repeat (6) step(0, 2'b00, 6'h00, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] fn;
      if ($urandom_range(9) < 7) fn = fn_tab[$urandom_range(7)];
      else fn = 6'($urandom);
      if (i % 700 == 699) do_reset();
      step($urandom_range(9) < 7, 2'($urandom), fn,
           $urandom_range(3) != 0, $urandom_range(19) == 0);
    end
    repeat (MDC + 3) step(0, 2'b00, 6'h00, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
